// File: rtl/serial_alu_pkg.sv
// Shared types and opcode decode for the bit-serial ALU sequencer.
package serial_alu_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_XOR  = 3'b011,
    OP_SUB  = 3'b100,
    OP_NOR  = 3'b101,
    OP_NAND = 3'b110,
    OP_RSUB = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam logic [1:0] SEL_AND = 2'b00;
  localparam logic [1:0] SEL_OR  = 2'b01;
  localparam logic [1:0] SEL_SUM = 2'b10;
  localparam logic [1:0] SEL_XOR = 2'b11;

  typedef struct packed {
    logic       a_inv;
    logic       b_inv;
    logic [1:0] sel;
  } slice_ctrl_t;

  typedef struct packed {
    slice_ctrl_t ctrl;
    logic        c_init;
    logic        arith;
  } decode_t;

  function automatic decode_t decode_op(alu_op_e op);
    decode_t d;
    d = '0;
    case (op)
      OP_AND:  d.ctrl = '{1'b0, 1'b0, SEL_AND};
      OP_OR:   d.ctrl = '{1'b0, 1'b0, SEL_OR};
      OP_ADD:  begin d.ctrl = '{1'b0, 1'b0, SEL_SUM}; d.arith = 1'b1; end
      OP_XOR:  d.ctrl = '{1'b0, 1'b0, SEL_XOR};
      OP_SUB:  begin d.ctrl = '{1'b0, 1'b1, SEL_SUM}; d.arith = 1'b1; d.c_init = 1'b1; end
      OP_NOR:  d.ctrl = '{1'b1, 1'b1, SEL_AND};
      OP_NAND: d.ctrl = '{1'b1, 1'b1, SEL_OR};
      OP_RSUB: begin d.ctrl = '{1'b1, 1'b0, SEL_SUM}; d.arith = 1'b1; d.c_init = 1'b1; end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/shift_reg_n.sv
// Loadable right-shift register with serial input at the MSB.
module shift_reg_n #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n)     q <= '0;
    else if (load)  q <= d;
    else if (shift) q <= {sin, q[WIDTH-1:1]};
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer driving an external 1-bit slice, LSB first.
// Optional overflow/negative flag ports enabled by SERIAL_ALU_FLAGS_EN.
module serial_alu_ctrl
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_a_inv,
  output logic             slice_b_inv,
  output logic             slice_c_in,
  output logic             slice_s1,
  output logic             slice_s0,
  input  logic             slice_x,
  input  logic             slice_c_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
`ifdef SERIAL_ALU_FLAGS_EN
  ,
  output logic             overflow,
  output logic             negative
`endif
);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  slice_ctrl_t      ctrl_q;
  logic             arith_q;
  logic             c_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [WIDTH-1:0] final_res;
  logic             accept, running;
  decode_t          dec;
  logic             unused_ok;

  assign accept    = in_valid && in_ready;
  assign running   = (state == RUN);
  assign dec       = decode_op(alu_op_e'(op));
  assign final_res = {slice_x, res_q[WIDTH-1:1]};
  assign result    = res_q;
  assign unused_ok = ^{a_q[WIDTH-1:1], b_q[WIDTH-1:1]};

  shift_reg_n #(.WIDTH(WIDTH)) u_a_sh (
    .clk(clk), .rst_n(rst_n), .load(accept), .shift(running),
    .d(op_a), .sin(1'b0), .q(a_q)
  );

  shift_reg_n #(.WIDTH(WIDTH)) u_b_sh (
    .clk(clk), .rst_n(rst_n), .load(accept), .shift(running),
    .d(op_b), .sin(1'b0), .q(b_q)
  );

  shift_reg_n #(.WIDTH(WIDTH)) u_res_sh (
    .clk(clk), .rst_n(rst_n), .load(accept), .shift(running),
    .d('0), .sin(slice_x), .q(res_q)
  );

  // Slice is driven only while running so it sees quiet inputs otherwise.
  assign slice_a     = running & a_q[0];
  assign slice_b     = running & b_q[0];
  assign slice_a_inv = running & ctrl_q.a_inv;
  assign slice_b_inv = running & ctrl_q.b_inv;
  assign slice_s1    = running & ctrl_q.sel[1];
  assign slice_s0    = running & ctrl_q.sel[0];
  assign slice_c_in  = running & c_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cnt       <= '0;
      ctrl_q    <= '0;
      arith_q   <= 1'b0;
      c_q       <= 1'b0;
      carry     <= 1'b0;
      zero      <= 1'b0;
`ifdef SERIAL_ALU_FLAGS_EN
      overflow  <= 1'b0;
      negative  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= RUN;
            in_ready <= 1'b0;
            cnt      <= '0;
            ctrl_q   <= dec.ctrl;
            arith_q  <= dec.arith;
            c_q      <= dec.c_init;
          end
        end
        RUN: begin
          c_q <= slice_c_out;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            carry     <= arith_q & slice_c_out;
            zero      <= (final_res == '0);
`ifdef SERIAL_ALU_FLAGS_EN
            overflow  <= arith_q & (c_q ^ slice_c_out);
            negative  <= slice_x;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_alu_ctrl.md
Name: serial_alu_ctrl

Overview:
Bit-serial ALU sequencer. It accepts WIDTH-bit operands and an opcode over a valid/ready handshake, then drives an external 1-bit ALU slice one bit per cycle, LSB first. It feeds the slice's carry back through a register and assembles the WIDTH-bit result plus flags. It is the controlling end of the slice interface (a, b, a_inv, b_inv, c_in, s1, s0 -> x, c_out) and sits between the lab's operand source and that slice.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH), bit-counter width (derived; do not override).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  reset, synchronous, active-low.
in_valid  input  1  operands/opcode valid.
in_ready  output  1  block can accept; high only in IDLE.
op  input  3  opcode: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 SUB (A-B), 101 NOR, 110 NAND, 111 RSUB (B-A).
op_a  input  WIDTH  operand A.
op_b  input  WIDTH  operand B.
slice_a, slice_b  output  1  current operand bits to the slice.
slice_a_inv, slice_b_inv  output  1  slice input inverters.
slice_c_in  output  1  slice carry-in.
slice_s1, slice_s0  output  1  slice mux select: 00 AND, 01 OR, 10 SUM, 11 XOR.
slice_x  input  1  slice result bit; combinational from the slice outputs.
slice_c_out  input  1  slice carry-out.
out_valid  output  1  result valid; high only in DONE.
out_ready  input  1  consumer accepts the result.
result  output  WIDTH  assembled result.
carry  output  1  final slice_c_out for ADD/SUB/RSUB; 0 for logic ops. For SUB/RSUB, 1 means no borrow.
zero  output  1  result == 0.

Behaviour:
- Reset: all outputs 0 except in_ready = 1 and state = IDLE. Applies on any cycle, including mid-RUN. A partial result is discarded.
- State machine:
  - IDLE: accepts when in_valid && in_ready. Latches op_a and op_b into shift registers, decodes op into registered controls, sets bit counter to 0, sets carry register to 1 for SUB/RSUB and 0 otherwise, then goes to RUN.
  - RUN: exactly WIDTH cycles. Each edge: result shift register shifts right with slice_x entering the MSB; operand registers shift right; carry register <= slice_c_out; counter++. At the edge where counter == WIDTH-1, go to DONE.
  - DONE: out_valid = 1 and result/carry/zero held stable. On out_ready, go to IDLE.
- Slice drive:
  - Combinational from registers: slice_a = A_sh[0], slice_b = B_sh[0], slice_c_in = carry register.
  - Inverts/selects per op:
    - AND: 0,0,00
    - OR: 0,0,01
    - ADD: 0,0,10
    - XOR: 0,0,11
    - SUB: 0,1,10
    - NOR: 1,1,00
    - NAND: 1,1,01
    - RSUB: 1,0,10
  - In IDLE and DONE all slice outputs are 0.
- Latency: out_valid rises after exactly WIDTH+1 rising edges, counting the accepting edge. Throughput is one operation per WIDTH+2 cycles when out_ready is held high.
- Simultaneous events:
  - in_valid is ignored in RUN and DONE (in_ready low). A request held during DONE is accepted on the first IDLE cycle after out_ready.
  - out_ready outside DONE has no effect.
- carry and zero are computed at the RUN->DONE edge from final values.
- Input stability: operands and op are sampled only at acceptance. Later changes have no effect.

Optional Feature:
Macro: SERIAL_ALU_FLAGS_EN.
- Defined: adds output ports overflow (1) and negative (1).
  - negative = result[WIDTH-1].
  - overflow = carry into MSB XOR carry out of MSB for ADD/SUB/RSUB, 0 for logic ops. Capture the carry into the MSB as the slice_c_in value on the final RUN cycle.
  - Both reset to 0 and are valid while out_valid = 1.
- Undefined: ports absent; no extra registers.

Decomposition:
- Package serial_alu_pkg:
  - alu_op_e enum (3 bits, encodings above).
  - state_e enum {IDLE, RUN, DONE}.
  - slice_ctrl_t struct {a_inv, b_inv, sel[1:0]}.
  - Function decode_op(alu_op_e) returning slice_ctrl_t and initial carry.
- Sub-module shift_reg_n: parameterised WIDTH, load/shift enable, serial in at MSB, parallel out; instantiated three times (A, B, result).
- The bench provides a behavioural 1-bit slice model.

Test Plan:
- ADD, A=0x7F, B=0x01 -> result 0x80, carry 0, zero 0, overflow 1 (FLAGS_EN); out_valid exactly 9 edges after acceptance.
- SUB, A=0x05, B=0x07 -> result 0xFE, carry 0 (borrow), negative 1; RSUB with the same operands -> 0x02, carry 1.
- SUB, A=0x10, B=0x10 -> result 0x00, carry 1, zero 1; NOR 0x0F,0xF0 -> 0x00, zero 1; NAND 0xFF,0x0F -> 0xF0.
- AND 0xF0,0x3C -> 0x30; OR -> 0xFC; XOR -> 0xCC; check slice_s1/s0 and inverts each RUN cycle and all slice outputs 0 in IDLE.
- Backpressure: hold out_ready=0 for 5 cycles in DONE with a new in_valid pending -> result stable, in_ready 0; on out_ready=1, next op accepted on the following cycle.
- rst_n=0 on the 4th RUN cycle of an ADD -> next edge IDLE, in_ready 1, out_valid 0, result 0; a subsequent ADD 0x01+0x01 -> 0x02.
